// File: rtl/fns_enc_29_if.sv
// Handshake bundle for the 29-bit FNS encoder: binary word in, FNS codeword out.
// master drives the input word and out_ready; slave is the encoder.
interface fns_enc_29_if;
    logic        in_valid;
    logic        in_ready;
    logic [20:0] datain;
    logic        out_valid;
    logic        out_ready;
    logic [28:0] codeout;
    logic        err;

    modport master (
        output in_valid,
        output datain,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  codeout,
        input  err
    );

    modport slave (
        input  in_valid,
        input  datain,
        input  out_ready,
        output in_ready,
        output out_valid,
        output codeout,
        output err
    );
endinterface

// File: rtl/fns_enc_29.sv
// Sequential greedy Fibonacci-numeral-system encoder, 21-bit binary to 29-bit FNS, one weight per cycle.
// Optional input range check enabled by defining FNS_ENC_RANGE_CHECK_EN.
module fns_enc_29 (
    input  logic          clk,
    input  logic          rst,
    fns_enc_29_if.slave   bus
);

    localparam logic [20:0] MaxEncodable = 21'd1346268;

    typedef enum logic [1:0] {
        IDLE,
        ENC,
        DONE
    } state_t;

    state_t      state_q, state_d;
    logic [20:0] rem_q, rem_d;
    logic [4:0]  k_q, k_d;
    logic [28:0] code_q, code_d;
    logic [20:0] weight;

    // Weight W(idx+1) of code bit idx; W1=1, W2=2, Wk=Wk-1+Wk-2.
    function automatic logic [20:0] fnsWeight(input logic [4:0] idx);
        case (idx)
            5'd0:    fnsWeight = 21'd1;
            5'd1:    fnsWeight = 21'd2;
            5'd2:    fnsWeight = 21'd3;
            5'd3:    fnsWeight = 21'd5;
            5'd4:    fnsWeight = 21'd8;
            5'd5:    fnsWeight = 21'd13;
            5'd6:    fnsWeight = 21'd21;
            5'd7:    fnsWeight = 21'd34;
            5'd8:    fnsWeight = 21'd55;
            5'd9:    fnsWeight = 21'd89;
            5'd10:   fnsWeight = 21'd144;
            5'd11:   fnsWeight = 21'd233;
            5'd12:   fnsWeight = 21'd377;
            5'd13:   fnsWeight = 21'd610;
            5'd14:   fnsWeight = 21'd987;
            5'd15:   fnsWeight = 21'd1597;
            5'd16:   fnsWeight = 21'd2584;
            5'd17:   fnsWeight = 21'd4181;
            5'd18:   fnsWeight = 21'd6765;
            5'd19:   fnsWeight = 21'd10946;
            5'd20:   fnsWeight = 21'd17711;
            5'd21:   fnsWeight = 21'd28657;
            5'd22:   fnsWeight = 21'd46368;
            5'd23:   fnsWeight = 21'd75025;
            5'd24:   fnsWeight = 21'd121393;
            5'd25:   fnsWeight = 21'd196418;
            5'd26:   fnsWeight = 21'd317811;
            5'd27:   fnsWeight = 21'd514229;
            5'd28:   fnsWeight = 21'd832040;
            default: fnsWeight = 21'd0;
        endcase
    endfunction

    assign weight = fnsWeight(k_q);

`ifdef FNS_ENC_RANGE_CHECK_EN
    logic err_q, err_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    always_comb begin
        err_d = err_q;
        if (state_q == IDLE && bus.in_valid) begin
            err_d = (bus.datain > MaxEncodable);
        end
    end

    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            rem_q   <= '0;
            k_q     <= '0;
            code_q  <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            k_q     <= k_d;
            code_q  <= code_d;
        end
    end

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        k_d     = k_q;
        code_d  = code_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    rem_d   = bus.datain;
                    k_d     = 5'd28;
                    code_d  = '0;
                    state_d = ENC;
                end
            end
            ENC: begin
                if (rem_q >= weight) begin
                    code_d = code_q | (29'd1 << k_q);
                    rem_d  = rem_q - weight;
                end
                // k stays at 0 after the last step instead of wrapping.
                if (k_q == 5'd0) begin
                    state_d = DONE;
`ifdef FNS_ENC_RANGE_CHECK_EN
                    if (err_q) begin
                        code_d = '0;
                    end
`endif
                end else begin
                    k_d = k_q - 5'd1;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.codeout   = code_q;

endmodule

// File: tb/tb_fns_enc_29.sv
// Self-checking bench for fns_enc_29: directed vector table, handshake/reset sequences and a decoder-checked random sweep.
module tb_fns_enc_29;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   failures = 0;
    int   cycleCount = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cycleCount <= cycleCount + 1;

    fns_enc_29_if bus ();

    fns_enc_29 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        logic [20:0] data;
        logic [28:0] code;
        logic        err;
        logic        inRange;
    } vec_t;

    vec_t vecs[12];

    // Independent decoder: weights built by the Fibonacci recurrence.
    function automatic logic [31:0] fnsDecode(input logic [28:0] c);
        logic [31:0] a, b, t, sum;
        a = 1;
        b = 2;
        sum = 0;
        for (int i = 0; i < 29; i++) begin
            if (c[i]) sum = sum + a;
            t = a + b;
            a = b;
            b = t;
        end
        return sum;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [20:0] value, input int stall,
                                 output logic [28:0] code, output logic errOut,
                                 output int latency, output int acceptCycle);
        int waitCnt;
        waitCnt = 0;
        while (!bus.in_ready && waitCnt < 100) begin
            @(posedge clk); #1;
            waitCnt++;
        end
        if (waitCnt >= 100) checkOutput("inReadyWait", {31'd0, bus.in_ready}, 32'd1);
        bus.in_valid = 1'b1;
        bus.datain   = value;
        @(posedge clk); #1;
        acceptCycle  = cycleCount;
        bus.in_valid = 1'b0;
        latency = 0;
        while (!bus.out_valid && latency < 100) begin
            @(posedge clk); #1;
            latency++;
        end
        code   = bus.codeout;
        errOut = bus.err;
        for (int s = 0; s < stall; s++) begin
            @(posedge clk); #1;
            checkOutput("stallValid", {31'd0, bus.out_valid}, 32'd1);
            checkOutput("stallCode", {3'd0, bus.codeout}, {3'd0, code});
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        checkOutput("readyAfterPop", {30'd0, bus.in_ready, bus.out_valid}, 32'd2);
    endtask

    logic [28:0] code, code2;
    logic        errOut;
    int          latency, acc1, acc2, seenValid;
    logic [20:0] value;

    initial begin
        vecs[0]  = '{21'd0,       29'h0000000, 1'b0, 1'b1};
        vecs[1]  = '{21'd1,       29'h0000001, 1'b0, 1'b1};
        vecs[2]  = '{21'd2,       29'h0000002, 1'b0, 1'b1};
        vecs[3]  = '{21'd3,       29'h0000004, 1'b0, 1'b1};
        vecs[4]  = '{21'd4,       29'h0000005, 1'b0, 1'b1};
        vecs[5]  = '{21'd7,       29'h000000A, 1'b0, 1'b1};
        vecs[6]  = '{21'd12,      29'h0000015, 1'b0, 1'b1};
        vecs[7]  = '{21'd100,     29'h0000214, 1'b0, 1'b1};
        vecs[8]  = '{21'd1000,    29'h0004020, 1'b0, 1'b1};
        vecs[9]  = '{21'd1346268, 29'h15555555, 1'b0, 1'b1};
        vecs[10] = '{21'd514229,  29'h08000000, 1'b0, 1'b1};
`ifdef FNS_ENC_RANGE_CHECK_EN
        vecs[11] = '{21'd1346269, 29'h0000000, 1'b1, 1'b0};
`else
        vecs[11] = '{21'd1346269, 29'h18000000, 1'b0, 1'b0};
`endif

        rst           = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.datain    = '0;
        #2 rst = 1'b1;
        #1;
        checkOutput("resetReady", {31'd0, bus.in_ready}, 32'd1);
        checkOutput("resetValid", {31'd0, bus.out_valid}, 32'd0);
        checkOutput("resetCode", {3'd0, bus.codeout}, 32'd0);
        checkOutput("resetErr", {31'd0, bus.err}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i].data, i % 3, code, errOut, latency, acc1);
            checkOutput($sformatf("vecCode%0d", i), {3'd0, code}, {3'd0, vecs[i].code});
            checkOutput($sformatf("vecErr%0d", i), {31'd0, errOut}, {31'd0, vecs[i].err});
            checkOutput($sformatf("vecLatency%0d", i), latency, 32'd29);
            if (vecs[i].inRange) begin
                checkOutput($sformatf("vecDecode%0d", i), fnsDecode(code), {11'd0, vecs[i].data});
                checkOutput($sformatf("vecAdjacent%0d", i), {3'd0, code & (code >> 1)}, 32'd0);
            end
        end

        applyStimulus(21'd832040, 0, code, errOut, latency, acc1);
        applyStimulus(21'd514229, 0, code2, errOut, latency, acc2);
        checkOutput("b2bFirst", {3'd0, code}, 32'h10000000);
        checkOutput("b2bSecond", {3'd0, code2}, 32'h08000000);
        checkOutput("b2bPeriod", acc2 - acc1, 32'd31);

        applyStimulus(21'd7, 5, code, errOut, latency, acc1);
        checkOutput("stallWordCode", {3'd0, code}, 32'h0000000A);

        // in_valid kept high through ENC must not start a second word.
        bus.in_valid = 1'b1;
        bus.datain   = 21'd7;
        @(posedge clk); #1;
        bus.datain = 21'd4;
        for (int s = 0; s < 5; s++) begin
            checkOutput("encInReady", {31'd0, bus.in_ready}, 32'd0);
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        latency = 0;
        while (!bus.out_valid && latency < 100) begin
            @(posedge clk); #1;
            latency++;
        end
        checkOutput("encIgnoreValid", {31'd0, bus.out_valid}, 32'd1);
        checkOutput("encIgnoreCode", {3'd0, bus.codeout}, 32'h0000000A);

        // Asynchronous reset in the middle of a clock cycle while in DONE.
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        checkOutput("midResetReady", {31'd0, bus.in_ready}, 32'd1);
        checkOutput("midResetValid", {31'd0, bus.out_valid}, 32'd0);
        checkOutput("midResetCode", {3'd0, bus.codeout}, 32'd0);
        checkOutput("midResetErr", {31'd0, bus.err}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        bus.in_valid = 1'b1;
        bus.datain   = 21'd1000;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        #2 rst = 1'b0;
        seenValid = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (bus.out_valid) seenValid++;
        end
        checkOutput("abortNoValid", seenValid, 32'd0);
        applyStimulus(21'd1000, 0, code, errOut, latency, acc1);
        checkOutput("afterAbortCode", {3'd0, code}, 32'h00004020);
        checkOutput("afterAbortLatency", latency, 32'd29);

        for (int n = 0; n < 300; n++) begin
            value = 21'($urandom_range(0, 1346268));
            applyStimulus(value, $urandom_range(0, 3), code, errOut, latency, acc1);
            checkOutput("randDecode", fnsDecode(code), {11'd0, value});
            checkOutput("randAdjacent", {3'd0, code & (code >> 1)}, 32'd0);
            checkOutput("randErr", {31'd0, errOut}, 32'd0);
            checkOutput("randLatency", latency, 32'd29);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
